pipe_barrier_skid: RTL

- Parametrised pipeline barrier for the LC-3b pipeline. It generalises the fixed IR/PC/valid stage register to an arbitrary-width payload.
- Replaces the global stall with a per-stage valid/ready handshake. A 2-entry skid buffer keeps in_ready registered, so back-pressure does not form a combinational path through the stage.
- Adds a synchronous flush for branch/exception squash, plus saturating stall and squash counters for performance analysis.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...), carrying whatever bundle the stage concatenates into in_data.

---
 rtl/pipe_barrier_skid.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pipe_barrier_skid.sv
// pipe_barrier_skid: valid/ready pipeline barrier with a 2-entry skid buffer.
// in_ready depends only on registered state (plus flush/reset), so downstream
// back-pressure never propagates combinationally through the stage. A
// synchronous flush squashes held beats. Saturating counters record stall
// cycles and squashed beats.
module pipe_barrier_skid #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] squash_count
);

    // Occupancy encoded as {main_v, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_main_d;
    logic [WIDTH-1:0]      r_skid_d;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic [CNT_WIDTH-1:0]  r_squash_cnt;

    logic                  w_main_v;
    logic                  w_skid_v;
    logic                  w_accept;
    logic                  w_fire;
    logic [1:0]            w_held;

    // Saturating add of a small increment (0..2); never wraps to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] base,
        input logic [1:0]           inc
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, base} + {{(CNT_WIDTH-1){1'b0}}, inc};
        if (sum[CNT_WIDTH]) begin
            sat_add = '1;
        end else begin
            sat_add = sum[CNT_WIDTH-1:0];
        end
    endfunction

    assign w_main_v     = r_state[1];
    assign w_skid_v     = r_state[0];
    assign w_held       = {1'b0, w_main_v} + {1'b0, w_skid_v};

    assign out_data     = r_main_d;
    assign out_valid    = w_main_v & ~flush;
    assign in_ready     = ~w_skid_v & ~flush & ~reset;
    assign w_accept     = in_valid & in_ready;
    assign w_fire       = out_valid & out_ready;

    assign stall_count  = r_stall_cnt;
    assign squash_count = r_squash_cnt;

    // Occupancy FSM and payload registers: reset > flush > handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_EMPTY;
            r_main_d <= RESET_VAL;
            r_skid_d <= RESET_VAL;
        end else if (flush) begin
            // Payload is left as-is; out_valid masks it until the next accept.
            r_state  <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state  <= ST_ONE;
                        r_main_d <= in_data;
                    end else begin
                        r_state  <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_fire) begin
                        r_main_d <= in_data;
                    end else if (w_accept) begin
                        r_state  <= ST_TWO;
                        r_skid_d <= in_data;
                    end else if (w_fire) begin
                        r_state  <= ST_EMPTY;
                    end else begin
                        r_state  <= ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the output side can move.
                    if (w_fire) begin
                        r_state  <= ST_ONE;
                        r_main_d <= r_skid_d;
                    end else begin
                        r_state  <= ST_TWO;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a known empty state.
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Performance counters: stalled-output cycles and beats squashed by flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_squash_cnt <= '0;
        end else if (flush) begin
            r_squash_cnt <= sat_add(r_squash_cnt, w_held);
        end else if (out_valid && !out_ready) begin
            r_stall_cnt  <= sat_add(r_stall_cnt, 2'd1);
        end else begin
            r_stall_cnt  <= r_stall_cnt;
        end
    end

endmodule
